wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_pkg.sv | 27 ++
 rtl/load_align.sv | 39 +++
 rtl/wb_stage.sv | 84 ++++++++
 tb/tb_wb_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared writeback-stage definitions: result-source codes, load funct3 codes, stage register layout.
// Imported by load_align and wb_stage.
package wb_pkg;

   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_LOAD = 2'b01;
   localparam logic [1:0] WB_SEL_PC4  = 2'b10;
   localparam logic [1:0] WB_SEL_CSR  = 2'b11;

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;

   typedef struct packed {
      logic        valid;
      logic        rf_we;
      logic [4:0]  rd;
      logic [1:0]  wb_sel;
      logic [2:0]  funct3;
      logic [31:0] alu;
      logic [31:0] pc;
      logic [31:0] csr;
   } wb_stage_t;

endpackage

// File: rtl/load_align.sv
// Load data extraction: picks the byte/halfword at offset and sign/zero-extends; purely combinational.
// No backpressure; unlisted funct3 codes return the full word.
module load_align
   import wb_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (offset)
         2'd0: byte_sel = rdata[7:0];
         2'd1: byte_sel = rdata[15:8];
         2'd2: byte_sel = rdata[23:16];
         2'd3: byte_sel = rdata[31:24];
         default: byte_sel = 8'h00;
      endcase
      // Halfword accesses use offset[1] only; offset[0] is ignored.
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      data = rdata;
      case (funct3)
         LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         LD_LH:   data = {{16{half_sel[15]}}, half_sel};
         LD_LBU:  data = {24'h000000, byte_sel};
         LD_LHU:  data = {16'h0000, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers MEM results, selects RF write data, optional decode bypass (WB_BYPASS_EN); 1-cycle latency.
// Backpressure: stall holds the stage register, flush invalidates it (flush wins over stall).
module wb_stage
   import wb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        in_rf_we,
   input  logic [4:0]  in_rd,
   input  logic [1:0]  in_wb_sel,
   input  logic [2:0]  in_funct3,
   input  logic [31:0] in_alu,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_csr,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] dmem_rdata,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [31:0] rf_rd1,
   input  logic [31:0] rf_rd2,
   output logic        we,
   output logic [4:0]  wa,
   output logic [31:0] wd,
   output logic        wb_valid,
   output logic [31:0] op1,
   output logic [31:0] op2
);

   wb_stage_t   st;
   logic [31:0] ld_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         st <= '0;
      end else if (flush) begin
         st.valid <= 1'b0;
      end else if (!stall) begin
         st.valid  <= in_valid;
         st.rf_we  <= in_rf_we;
         st.rd     <= in_rd;
         st.wb_sel <= in_wb_sel;
         st.funct3 <= in_funct3;
         st.alu    <= in_alu;
         st.pc     <= in_pc;
         st.csr    <= in_csr;
      end
   end

   load_align u_load_align (
      .rdata  (dmem_rdata),
      .offset (st.alu[1:0]),
      .funct3 (st.funct3),
      .data   (ld_data)
   );

   assign we       = st.valid & st.rf_we & (st.rd != 5'd0);
   assign wa       = st.rd;
   assign wb_valid = st.valid;

   always_comb begin
      wd = 32'h0;
      if (st.valid) begin
         case (st.wb_sel)
            WB_SEL_ALU:  wd = st.alu;
            WB_SEL_LOAD: wd = ld_data;
            WB_SEL_PC4:  wd = st.pc + 32'd4;
            WB_SEL_CSR:  wd = st.csr;
            default:     wd = 32'h0;
         endcase
      end
   end

`ifdef WB_BYPASS_EN
   // we is already 0 for x0, so ra==0 can never match a live write.
   assign op1 = (we && (wa == ra1)) ? wd : rf_rd1;
   assign op2 = (we && (wa == ra2)) ? wd : rf_rd2;
`else
   assign op1 = rf_rd1;
   assign op2 = rf_rd2;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage; expected values are hand-computed constants.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_rf_we;
   logic [4:0]  in_rd;
   logic [1:0]  in_wb_sel;
   logic [2:0]  in_funct3;
   logic [31:0] in_alu, in_pc, in_csr;
   logic        stall, flush;
   logic [31:0] dmem_rdata;
   logic [4:0]  ra1, ra2;
   logic [31:0] rf_rd1, rf_rd2;
   logic        we, wb_valid;
   logic [4:0]  wa;
   logic [31:0] wd, op1, op2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_rf_we(in_rf_we), .in_rd(in_rd),
      .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
      .in_alu(in_alu), .in_pc(in_pc), .in_csr(in_csr),
      .stall(stall), .flush(flush), .dmem_rdata(dmem_rdata),
      .ra1(ra1), .ra2(ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .we(we), .wa(wa), .wd(wd), .wb_valid(wb_valid),
      .op1(op1), .op2(op2)
   );

   // Apply one instruction on the falling edge, clock it in, sample 1 time unit after the edge.
   task automatic drive(input logic v, input logic rfwe, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] pc,
                        input logic [31:0] csr, input logic [31:0] dm);
      @(negedge clk);
      in_valid = v; in_rf_we = rfwe; in_rd = rd; in_wb_sel = sel;
      in_funct3 = f3; in_alu = alu; in_pc = pc; in_csr = csr; dmem_rdata = dm;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 1'b1, 5'd7, 2'b00, 3'b010, 32'h1234, 32'h40, 32'h9, 32'h0);
      total++;
      if (we !== 1'b0 || wa !== 5'd0 || wd !== 32'h0 || wb_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset got we=%b wa=%0d wd=%h v=%b exp all zero", we, wa, wd, wb_valid);
      end
      rst = 1'b0;
   endtask

   task automatic test_x0();
      drive(1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0, 32'h0);
      total++;
      if (we !== 1'b0 || wd !== 32'h1 || wb_valid !== 1'b1) begin
         bad++;
         $display("FAIL x0_write got we=%b wd=%h v=%b exp we=0 wd=00000001 v=1", we, wd, wb_valid);
      end
      drive(1'b1, 1'b0, 5'd3, 2'b00, 3'b000, 32'h77, 32'h0, 32'h0, 32'h0);
      total++;
      if (we !== 1'b0 || wa !== 5'd3 || wd !== 32'h77) begin
         bad++;
         $display("FAIL no_rf_we got we=%b wa=%0d wd=%h exp we=0 wa=3 wd=00000077", we, wa, wd);
      end
   endtask

   task automatic test_loads();
      drive(1'b1, 1'b1, 5'd2, 2'b01, 3'b000, 32'h3, 32'h0, 32'h0, 32'h80FF_0000);
      total++;
      if (wd !== 32'hFFFFFF80 || we !== 1'b1 || wa !== 5'd2) begin
         bad++;
         $display("FAIL lb got wd=%h we=%b wa=%0d exp wd=ffffff80 we=1 wa=2", wd, we, wa);
      end
      drive(1'b1, 1'b1, 5'd2, 2'b01, 3'b100, 32'h3, 32'h0, 32'h0, 32'h80FF_0000);
      total++;
      if (wd !== 32'h00000080) begin
         bad++; $display("FAIL lbu got=%h exp=00000080", wd);
      end
      drive(1'b1, 1'b1, 5'd4, 2'b01, 3'b000, 32'h1, 32'h0, 32'h0, 32'h0000_7F00);
      total++;
      if (wd !== 32'h0000007F) begin
         bad++; $display("FAIL lb_off1 got=%h exp=0000007f", wd);
      end
      drive(1'b1, 1'b1, 5'd4, 2'b01, 3'b001, 32'h2, 32'h0, 32'h0, 32'h8001_1234);
      total++;
      if (wd !== 32'hFFFF8001) begin
         bad++; $display("FAIL lh got=%h exp=ffff8001", wd);
      end
      drive(1'b1, 1'b1, 5'd4, 2'b01, 3'b101, 32'h2, 32'h0, 32'h0, 32'h8001_1234);
      total++;
      if (wd !== 32'h00008001) begin
         bad++; $display("FAIL lhu got=%h exp=00008001", wd);
      end
      drive(1'b1, 1'b1, 5'd4, 2'b01, 3'b001, 32'h3, 32'h0, 32'h0, 32'h8001_1234);
      total++;
      if (wd !== 32'hFFFF8001) begin
         bad++; $display("FAIL lh_odd got=%h exp=ffff8001", wd);
      end
      drive(1'b1, 1'b1, 5'd4, 2'b01, 3'b001, 32'h0, 32'h0, 32'h0, 32'h8001_9234);
      total++;
      if (wd !== 32'hFFFF9234) begin
         bad++; $display("FAIL lh_low got=%h exp=ffff9234", wd);
      end
      drive(1'b1, 1'b1, 5'd4, 2'b01, 3'b010, 32'h1, 32'h0, 32'h0, 32'h8234_5678);
      total++;
      if (wd !== 32'h82345678) begin
         bad++; $display("FAIL lw got=%h exp=82345678", wd);
      end
      drive(1'b1, 1'b1, 5'd4, 2'b01, 3'b111, 32'h3, 32'h0, 32'h0, 32'h8234_5678);
      total++;
      if (wd !== 32'h82345678) begin
         bad++; $display("FAIL f3_111_as_lw got=%h exp=82345678", wd);
      end
      drive(1'b1, 1'b1, 5'd4, 2'b01, 3'b011, 32'h2, 32'h0, 32'h0, 32'hC0DE_0001);
      total++;
      if (wd !== 32'hC0DE0001) begin
         bad++; $display("FAIL f3_011_as_lw got=%h exp=c0de0001", wd);
      end
   endtask

   task automatic test_pc_csr();
      drive(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0);
      total++;
      if (wd !== 32'h00000000) begin
         bad++; $display("FAIL pc4_wrap got=%h exp=00000000", wd);
      end
      drive(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'h0, 32'h0000_0100, 32'h0, 32'h0);
      total++;
      if (wd !== 32'h00000104) begin
         bad++; $display("FAIL pc4 got=%h exp=00000104", wd);
      end
      drive(1'b1, 1'b1, 5'd1, 2'b11, 3'b000, 32'h0, 32'h0, 32'h0000_DEAD, 32'h0);
      total++;
      if (wd !== 32'h0000DEAD) begin
         bad++; $display("FAIL csr got=%h exp=0000dead", wd);
      end
      drive(1'b0, 1'b1, 5'd1, 2'b11, 3'b000, 32'h0, 32'h0, 32'h0000_DEAD, 32'h0);
      total++;
      if (wd !== 32'h0 || we !== 1'b0 || wb_valid !== 1'b0) begin
         bad++; $display("FAIL invalid_wd got wd=%h we=%b v=%b exp 0/0/0", wd, we, wb_valid);
      end
   endtask

   task automatic test_stall_flush();
      drive(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 32'hA, 32'h0, 32'h0, 32'h0);
      stall = 1'b1;
      drive(1'b1, 1'b1, 5'd7, 2'b11, 3'b000, 32'h55, 32'h0, 32'h99, 32'h0);
      total++;
      if (wa !== 5'd5 || wd !== 32'hA || we !== 1'b1) begin
         bad++; $display("FAIL stall_hold got wa=%0d wd=%h we=%b exp wa=5 wd=0000000a we=1", wa, wd, we);
      end
      flush = 1'b1;
      drive(1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0, 32'h0);
      total++;
      if (wb_valid !== 1'b0 || we !== 1'b0 || wd !== 32'h0) begin
         bad++; $display("FAIL flush_stall got v=%b we=%b wd=%h exp 0/0/0", wb_valid, we, wd);
      end
      stall = 1'b0; flush = 1'b0;
      drive(1'b1, 1'b1, 5'd6, 2'b00, 3'b000, 32'h66, 32'h0, 32'h0, 32'h0);
      total++;
      if (wa !== 5'd6 || wd !== 32'h66 || wb_valid !== 1'b1) begin
         bad++; $display("FAIL after_flush got wa=%0d wd=%h v=%b exp 6/00000066/1", wa, wd, wb_valid);
      end
      stall = 1'b1; rst = 1'b1;
      drive(1'b1, 1'b1, 5'd9, 2'b00, 3'b000, 32'h99, 32'h0, 32'h0, 32'h0);
      total++;
      if (wb_valid !== 1'b0 || wa !== 5'd0 || wd !== 32'h0) begin
         bad++; $display("FAIL rst_in_stall got v=%b wa=%0d wd=%h exp 0/0/0", wb_valid, wa, wd);
      end
      stall = 1'b0; rst = 1'b0;
   endtask

   task automatic test_bypass();
      ra1 = 5'd1; rf_rd1 = 32'h9; ra2 = 5'd0; rf_rd2 = 32'h0;
      drive(1'b1, 1'b1, 5'd1, 2'b00, 3'b000, 32'h5, 32'h0, 32'h0, 32'h0);
`ifdef WB_BYPASS_EN
      total++;
      if (op1 !== 32'h5 || op2 !== 32'h0) begin
         bad++; $display("FAIL bypass_op1 got op1=%h op2=%h exp 00000005/00000000", op1, op2);
      end
`else
      total++;
      if (op1 !== 32'h9 || op2 !== 32'h0) begin
         bad++; $display("FAIL nobypass_op1 got op1=%h op2=%h exp 00000009/00000000", op1, op2);
      end
`endif
      ra2 = 5'd1; rf_rd2 = 32'h3; #1;
`ifdef WB_BYPASS_EN
      total++;
      if (op2 !== 32'h5) begin
         bad++; $display("FAIL bypass_op2 got=%h exp=00000005", op2);
      end
`else
      total++;
      if (op2 !== 32'h3) begin
         bad++; $display("FAIL nobypass_op2 got=%h exp=00000003", op2);
      end
`endif
      ra1 = 5'd0; rf_rd1 = 32'h77; ra2 = 5'd0; rf_rd2 = 32'h88;
      drive(1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 32'h5, 32'h0, 32'h0, 32'h0);
      total++;
      if (op1 !== 32'h77 || op2 !== 32'h88) begin
         bad++; $display("FAIL x0_no_bypass got op1=%h op2=%h exp 00000077/00000088", op1, op2);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 1'b1, 5'd10, 2'b00, 3'b000, 32'h100, 32'h0, 32'h0, 32'h0);
      total++;
      if (wa !== 5'd10 || wd !== 32'h100) begin
         bad++; $display("FAIL b2b_0 got wa=%0d wd=%h exp 10/00000100", wa, wd);
      end
      drive(1'b1, 1'b1, 5'd11, 2'b01, 3'b100, 32'h2, 32'h0, 32'h0, 32'h00AB_0000);
      total++;
      if (wa !== 5'd11 || wd !== 32'h000000AB) begin
         bad++; $display("FAIL b2b_1 got wa=%0d wd=%h exp 11/000000ab", wa, wd);
      end
      drive(1'b1, 1'b1, 5'd12, 2'b10, 3'b000, 32'h0, 32'h0000_1000, 32'h0, 32'h0);
      total++;
      if (wa !== 5'd12 || wd !== 32'h00001004) begin
         bad++; $display("FAIL b2b_2 got wa=%0d wd=%h exp 12/00001004", wa, wd);
      end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      in_valid = 1'b0; in_rf_we = 1'b0; in_rd = 5'd0; in_wb_sel = 2'b00;
      in_funct3 = 3'b000; in_alu = 32'h0; in_pc = 32'h0; in_csr = 32'h0;
      dmem_rdata = 32'h0; ra1 = 5'd0; ra2 = 5'd0; rf_rd1 = 32'h0; rf_rd2 = 32'h0;
      test_reset();
      test_x0();
      test_loads();
      test_pc_csr();
      test_stall_flush();
      test_bypass();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
